// File: rtl/spi_log_framer_pkg.sv
// Shared definitions for the SPI log framer: record/frame geometry, FSM
// state encoding and the frame builder.
// Optional build macro: SPI_LOG_VERBOSE_EN prefixes every frame with "READ".
package spi_log_framer_pkg;

  // One log record is {addr[23:0], len[7:0]}
  localparam int REC_W = 32;

`ifdef SPI_LOG_VERBOSE_EN
  localparam int FRAME_BYTES = 8;
  localparam int IDX_W       = 3;
  localparam logic [31:0] VERBOSE_HDR = 32'h5245_4144; // "READ"
`else
  localparam int FRAME_BYTES = 4;
  localparam int IDX_W       = 2;
`endif

  localparam int FRAME_W = FRAME_BYTES * 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Lay out a full frame, first byte on the wire in the top byte lane
  function automatic logic [FRAME_W-1:0] build_frame(input logic [REC_W-1:0] rec);
`ifdef SPI_LOG_VERBOSE_EN
    return {VERBOSE_HDR, rec};
`else
    return rec;
`endif
  endfunction

endpackage

// File: rtl/log_fifo.sv
// Synchronous record FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter. A push while full is
// accepted only when a pop retires an entry on the same edge.
module log_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             rd_en_s;
  logic             wr_en_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign level   = wr_ptr_r - rd_ptr_r;
  assign dout    = mem_r[rd_ptr_r[AW-1:0]];
  assign rd_en_s = pop && !empty;
  assign wr_en_s = push && (!full || rd_en_s);

  // Pointer update; contents are abandoned simply by clearing the pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; no reset needed since empty/level come from the pointers
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/spi_log_framer.sv
// SPI log framer: queues read records and serialises each one as a fixed
// byte frame onto the serial transmit stream. User parser bytes are merged
// at lower priority, only between frames. Nothing is issued while
// tx_inhibit is high or the sink is not ready.
// Optional build macro: SPI_LOG_VERBOSE_EN (8-byte frames with "READ" prefix).
module spi_log_framer
  import spi_log_framer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   log_strobe,
  input  logic [23:0]            log_addr,
  input  logic [7:0]             log_len,
  input  logic                   tx_inhibit,
  input  logic [7:0]             user_txd,
  input  logic                   user_txd_strobe,
  output logic                   user_txd_ready,
  input  logic                   uart_txd_ready,
  output logic [7:0]             uart_txd,
  output logic                   uart_txd_strobe,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [DROP_W-1:0]      dropped
);

  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BYTES - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  state_t             state_r, state_s;
  logic [FRAME_W-1:0] shift_r, shift_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [7:0]         txd_r, txd_s;
  logic               strobe_r, strobe_s;
  logic [DROP_W-1:0]  dropped_r;

  logic               go_s;
  logic               pop_s;
  logic               user_ready_s;
  logic               drop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [REC_W-1:0]   fifo_dout_s;
  logic [FRAME_W-1:0] frame_s;

  log_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (log_strobe),
    .pop   (pop_s),
    .din   ({log_addr, log_len}),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign go_s           = uart_txd_ready && !tx_inhibit;
  assign frame_s        = build_frame(fifo_dout_s);
  assign user_ready_s   = (state_r == ST_IDLE) && fifo_empty_s && go_s;
  // A record is lost only when the FIFO is full and nothing leaves this cycle
  assign drop_s         = log_strobe && fifo_full_s && !pop_s;

  assign user_txd_ready  = user_ready_s;
  assign uart_txd        = txd_r;
  assign uart_txd_strobe = strobe_r;
  assign dropped         = dropped_r;

  // Frame FSM next-state and byte selection; log frames win over user bytes
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    idx_s    = idx_r;
    txd_s    = txd_r;
    strobe_s = 1'b0;
    pop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (go_s && !fifo_empty_s) begin
          pop_s    = 1'b1;
          txd_s    = frame_s[FRAME_W-1 -: 8];
          shift_s  = {frame_s[FRAME_W-9:0], 8'h00};
          idx_s    = IDX_ONE;
          strobe_s = 1'b1;
          state_s  = ST_SEND;
        end else if (user_txd_strobe && user_ready_s) begin
          txd_s    = user_txd;
          strobe_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (go_s) begin
          txd_s    = shift_r[FRAME_W-1 -: 8];
          shift_s  = {shift_r[FRAME_W-9:0], 8'h00};
          strobe_s = 1'b1;
          if (idx_r == IDX_LAST) begin
            idx_s   = '0;
            state_s = ST_IDLE;
          end else begin
            idx_s   = idx_r + IDX_ONE;
          end
        end else begin
          state_s  = ST_SEND;
        end
      end
      default: begin
        idx_s   = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Frame FSM and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      shift_r  <= '0;
      idx_r    <= '0;
      txd_r    <= 8'h00;
      strobe_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      idx_r    <= idx_s;
      txd_r    <= txd_s;
      strobe_r <= strobe_s;
    end
  end

  // Saturating count of records lost to overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_r <= '0;
    end else if (drop_s && (dropped_r != DROP_MAX)) begin
      dropped_r <= dropped_r + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_spi_log_framer.sv
// Directed bench for spi_log_framer (default 4-byte frames, DEPTH=4).
// Expected bytes go into a queue when records are driven; a monitor on the
// falling edge pops and compares every issued byte.
module tb_spi_log_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        log_strobe = 1'b0;
  logic [23:0] log_addr = 24'h000000;
  logic [7:0]  log_len = 8'h00;
  logic        tx_inhibit = 1'b0;
  logic [7:0]  user_txd = 8'h00;
  logic        user_txd_strobe = 1'b0;
  logic        user_txd_ready;
  logic        uart_txd_ready = 1'b1;
  logic [7:0]  uart_txd;
  logic        uart_txd_strobe;
  logic [2:0]  fifo_level;
  logic [7:0]  dropped;

  int          n_assert = 0;
  int          n_fail = 0;
  int          strobe_cnt = 0;
  int          base;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;

  spi_log_framer #(.DEPTH(4), .DROP_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .log_strobe      (log_strobe),
    .log_addr        (log_addr),
    .log_len         (log_len),
    .tx_inhibit      (tx_inhibit),
    .user_txd        (user_txd),
    .user_txd_strobe (user_txd_strobe),
    .user_txd_ready  (user_txd_ready),
    .uart_txd_ready  (uart_txd_ready),
    .uart_txd        (uart_txd),
    .uart_txd_strobe (uart_txd_strobe),
    .fifo_level      (fifo_level),
    .dropped         (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic log_rec(input logic [23:0] a, input logic [7:0] l, input bit emitted);
    log_addr   = a;
    log_len    = l;
    log_strobe = 1'b1;
    if (emitted) begin
      exp_q.push_back(a[23:16]);
      exp_q.push_back(a[15:8]);
      exp_q.push_back(a[7:0]);
      exp_q.push_back(l);
    end
    tick();
    log_strobe = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every issued byte must be the next expected one
  always @(negedge clk) begin
    if (!reset && uart_txd_strobe) begin
      strobe_cnt++;
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_byte: observed %02h expected none", uart_txd);
      end
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        n_assert++;
        assert (uart_txd === exp_b) else begin
          n_fail++;
          $error("FAIL byte_value: observed %02h expected %02h", uart_txd, exp_b);
        end
      end
    end
  end

  // Hard time limit so a hung design still ends the run
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_txd", uart_txd, 8'h00);
    check("rst_strobe", uart_txd_strobe, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_dropped", dropped, 8'h00);
    reset = 1'b0;
    tick();
    tick();

    // Single record: strobes in cycles N+2..N+5, bytes 12 34 56 20
    log_rec(24'h123456, 8'h20, 1'b1);
    check("single_n1_strobe", uart_txd_strobe, 1'b0);
    check("single_n1_level", fifo_level, 3'd1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check("single_strobe_on", uart_txd_strobe, 1'b1);
    end
    tick();
    check("single_n6_strobe", uart_txd_strobe, 1'b0);
    check("single_level", fifo_level, 3'd0);
    check("single_q_empty", exp_q.size(), 0);
    repeat (2) tick();

    // Backpressure: sink not ready for 3 cycles after byte 1
    base = strobe_cnt;
    log_rec(24'h123456, 8'h20, 1'b1);
    tick();
    tick();
    uart_txd_ready = 1'b0;
    tick();
    check("bp_stall1", uart_txd_strobe, 1'b0);
    tick();
    check("bp_stall2", uart_txd_strobe, 1'b0);
    tick();
    check("bp_stall3", uart_txd_strobe, 1'b0);
    uart_txd_ready = 1'b1;
    tick();
    check("bp_resume1", uart_txd_strobe, 1'b1);
    tick();
    check("bp_resume2", uart_txd_strobe, 1'b1);
    tick();
    check("bp_done", uart_txd_strobe, 1'b0);
    check("bp_count", strobe_cnt - base, 4);
    repeat (2) tick();

    // Overflow: 6 records while inhibited, only the first 4 kept
    tx_inhibit = 1'b1;
    for (int k = 0; k < 6; k++) begin
      log_rec(24'h100000 + 24'(k * 24'h010203), 8'h10 + 8'(k), k < 4);
    end
    tick();
    check("ovf_level", fifo_level, 3'd4);
    check("ovf_dropped", dropped, 8'd2);
    check("ovf_inhibit_quiet", uart_txd_strobe, 1'b0);

    // Full + simultaneous pop: release inhibit in the same cycle as a push
    tx_inhibit = 1'b0;
    log_rec(24'hABCDEF, 8'h99, 1'b1);
    check("fullpop_level", fifo_level, 3'd4);
    check("fullpop_dropped", dropped, 8'd2);
    drain("ovf_drain");
    check("ovf_level_end", fifo_level, 3'd0);

    // User arbitration: byte offered mid-frame is refused
    log_rec(24'h0F1E2D, 8'h3C, 1'b1);
    tick();
    user_txd = 8'h41;
    user_txd_strobe = 1'b1;
    #1;
    check("user_busy_ready", user_txd_ready, 1'b0);
    tick();
    user_txd_strobe = 1'b0;
    drain("user_frame_drain");
    user_txd_strobe = 1'b1;
    #1;
    check("user_idle_ready", user_txd_ready, 1'b1);
    exp_q.push_back(8'h41);
    tick();
    user_txd_strobe = 1'b0;
    check("user_strobe", uart_txd_strobe, 1'b1);
    check("user_byte", uart_txd, 8'h41);
    tick();
    check("user_single", uart_txd_strobe, 1'b0);
    check("user_q_empty", exp_q.size(), 0);

    // Reset mid-frame after byte 1, with a second record still queued
    log_rec(24'h5A5A5A, 8'h11, 1'b1);
    log_rec(24'h606162, 8'h63, 1'b0);
    tick();
    @(negedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_txd", uart_txd, 8'h00);
    check("mid_rst_strobe", uart_txd_strobe, 1'b0);
    check("mid_rst_level", fifo_level, 3'd0);
    check("mid_rst_dropped", dropped, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_quiet", uart_txd_strobe, 1'b0);
    end
    base = strobe_cnt;
    log_rec(24'hC0FFEE, 8'h42, 1'b1);
    drain("post_rst_drain");
    check("post_rst_count", strobe_cnt - base, 4);
    check("post_rst_level", fifo_level, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_log_framer.md
Name: spi_log_framer

Overview:
Downstream of the SPI flash emulator's logging interface. Buffers read-transaction records (24-bit address + 8-bit length) in a small FIFO and serializes each as a fixed-length byte frame into the UART/USB serial transmit stream. Merges the user command parser's reply bytes at lower priority. Suppresses all output while the SPI bus is timing-critical.

Parameters:
DEPTH, 16, record FIFO entries; power of two, 2..256
DROP_W, 8, width of the saturating dropped-record counter

Ports:
clk  in  1  system clock (132 MHz domain)
reset  in  1  asynchronous, active-high; clears all state
log_strobe  in  1  one-cycle pulse: new record valid
log_addr  in  24  record address
log_len  in  8  record byte count
tx_inhibit  in  1  high while spi_critical; no bytes issued
user_txd  in  8  user parser byte
user_txd_strobe  in  1  user byte valid; honoured only while user_txd_ready
user_txd_ready  out  1  combinational: user byte accepted this cycle
uart_txd_ready  in  1  serial sink can accept a byte this cycle
uart_txd  out  8  byte to serial sink, registered
uart_txd_strobe  out  1  one-cycle byte-valid pulse, registered
fifo_level  out  $clog2(DEPTH)+1  records held
dropped  out  DROP_W  records lost to overflow, saturating

Behaviour:
- Reset values: uart_txd=0, uart_txd_strobe=0, fifo_level=0, dropped=0. FIFO is empty and the FSM is in IDLE.
- go = uart_txd_ready && !tx_inhibit, sampled in the current cycle.
- Push: on log_strobe, {log_addr, log_len} is written when not full.
  - If full and no pop occurs in the same cycle: the record is discarded and dropped increments, saturating at all-ones.
  - If full and a pop occurs in the same cycle: the push is accepted and the level is unchanged.
- There is no same-cycle bypass. A record pushed at edge N can pop no earlier than edge N+1.
- FSM states are IDLE and SEND. byte_idx is 2 bits, counting frame bytes 0..FRAME_BYTES-1.
  - IDLE, FIFO non-empty, go: pop the record. Register byte 0 = addr[23:16] on uart_txd with strobe=1. Load the remaining bytes into the shift register, set byte_idx=1, go to SEND.
  - SEND, go: emit the next byte MSB-first with strobe=1, then byte_idx++. After the last byte, return to IDLE.
  - SEND, !go: hold the state, strobe=0. The frame resumes without loss or duplication.
- Frame byte order: addr[23:16], addr[15:8], addr[7:0], len.
- Latency: with go held high, FIFO empty and FSM in IDLE, a log_strobe in cycle N gives uart_txd_strobe high in cycles N+2..N+5.
- user_txd_ready = (state==IDLE) && FIFO empty && go.
  - On user_txd_strobe && user_txd_ready: uart_txd <= user_txd and strobe=1 on the next edge.
  - A user strobe while not ready is ignored; the user parser owns retry.
- Log frames always take priority. A frame is never interleaved with user bytes.
- At most one uart_txd_strobe per cycle. uart_txd_strobe is 0 in any cycle where no byte is issued.
- Reset asserted mid-frame: the partial frame is abandoned and FIFO contents are lost. No byte is issued until reset deasserts.

Optional Feature:
- Macro: SPI_LOG_VERBOSE_EN.
- Defined: every frame is prefixed with ASCII "READ" (0x52 0x45 0x41 0x44). FRAME_BYTES=8, byte_idx widens to 3 bits, first data byte appears in cycle N+6.
- Undefined: FRAME_BYTES=4 as described above.

Decomposition:
- Shared include spi_log_defs.vh holds:
  - FRAME_BYTES;
  - the verbose header constant;
  - the record width (32).
- Sub-module log_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
  - Async active-high reset.
  - Pointers carry one extra wrap bit to distinguish full from empty.

Test Plan:
- Single record: addr 0x123456, len 0x20, go high → strobe cycles N+2..N+5 with bytes 12 34 56 20; fifo_level returns to 0.
- Backpressure: drop uart_txd_ready for 3 cycles after byte 1 → output stalls, then 56 20 follow; exactly 4 strobes total.
- Overflow: DEPTH=4, tx_inhibit=1, 6 log_strobes → fifo_level=4, dropped=2. Release inhibit → first 4 records emitted in order.
- Full + simultaneous pop: FIFO full, log_strobe in the same cycle as a pop → dropped unchanged, level stays 4, record emitted later.
- User arbitration: user_txd=0x41 strobed during a frame → user_txd_ready=0 and byte ignored; after the frame, 0x41 is accepted with a strobe on the next edge.
- Reset mid-frame after byte 1 → outputs 0, level 0. A new record afterwards yields a clean 4-byte frame.
